maq_h: RTL and testbench

- Hour stage of the clock chain; the terminal consumer of the minute stage's hour-carry pulse.
- Counts hours in BCD, in either 24 h mode or 12 h AM/PM mode, selected by parameter.
- Accepts a manual hour-adjust input from the time-set logic.
- Emits a one-cycle day-rollover pulse for a future date stage.

---
 rtl/maq_h.sv | 104 ++++++++++
 tb/tb_maq_h.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/maq_h.sv
`default_nettype none
// ============================================================================
// maq_h : BCD hour stage (24 h or 12 h AM/PM) with day-rollover pulse
// Rev 1.0
// ============================================================================
module maq_h #(
  parameter bit MODO_24H = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       incrementa_hora,
  input  logic       ajuste_hora,
  output logic [3:0] bcd_h_lsd,
  output logic [1:0] bcd_h_msd,
  output logic       pm,
  output logic       incrementa_dia
);

  localparam logic [3:0] LSD_RST = MODO_24H ? 4'd0 : 4'd2;
  localparam logic [1:0] MSD_RST = MODO_24H ? 2'd0 : 2'd1;

  logic [3:0] lsd_q, lsd_d;
  logic [1:0] msd_q, msd_d;
  logic       pm_q, pm_d;
  logic       dia_q, dia_d;
  logic       ajuste_q;
  logic       step;
  logic       legal;

  assign step = incrementa_hora | (ajuste_hora & ~ajuste_q);

  always_comb begin
    if (MODO_24H)
      legal = ((msd_q < 2'd2) && (lsd_q <= 4'd9)) || ((msd_q == 2'd2) && (lsd_q <= 4'd3));
    else
      legal = ((msd_q == 2'd0) && (lsd_q >= 4'd1) && (lsd_q <= 4'd9)) ||
              ((msd_q == 2'd1) && (lsd_q <= 4'd2));
  end

  always_comb begin
    lsd_d = lsd_q;
    msd_d = msd_q;
    pm_d  = pm_q;
    dia_d = 1'b0;
    if (step) begin
      // Corrupted digits fall back to the reset hour without a day pulse
      if (!legal) begin
        lsd_d = LSD_RST;
        msd_d = MSD_RST;
        pm_d  = 1'b0;
      end else if (MODO_24H) begin
        if ((msd_q == 2'd2) && (lsd_q == 4'd3)) begin
          lsd_d = 4'd0;
          msd_d = 2'd0;
          dia_d = incrementa_hora;
        end else if (lsd_q == 4'd9) begin
          lsd_d = 4'd0;
          msd_d = msd_q + 2'd1;
        end else begin
          lsd_d = lsd_q + 4'd1;
        end
        pm_d = (msd_d == 2'd2) || ((msd_d == 2'd1) && (lsd_d >= 4'd2));
      end else begin
        if ((msd_q == 2'd1) && (lsd_q == 4'd2)) begin
          lsd_d = 4'd1;
          msd_d = 2'd0;
        end else if ((msd_q == 2'd1) && (lsd_q == 4'd1)) begin
          // 11 PM -> 12 AM is the day wrap; 11 AM -> 12 PM is not
          lsd_d = 4'd2;
          pm_d  = ~pm_q;
          dia_d = incrementa_hora & pm_q;
        end else if (lsd_q == 4'd9) begin
          lsd_d = 4'd0;
          msd_d = 2'd1;
        end else begin
          lsd_d = lsd_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lsd_q    <= LSD_RST;
      msd_q    <= MSD_RST;
      pm_q     <= 1'b0;
      dia_q    <= 1'b0;
      ajuste_q <= 1'b0;
    end else begin
      lsd_q    <= lsd_d;
      msd_q    <= msd_d;
      pm_q     <= pm_d;
      dia_q    <= dia_d;
      ajuste_q <= ajuste_hora;
    end
  end

  assign bcd_h_lsd      = lsd_q;
  assign bcd_h_msd      = msd_q;
  assign pm             = pm_q;
  assign incrementa_dia = dia_q;

endmodule
`default_nettype wire

// File: tb/tb_maq_h.sv
`default_nettype none
// ============================================================================
// tb_maq_h : scoreboard bench driving a 24 h and a 12 h instance in parallel
// Rev 1.0
// ============================================================================
module tb_maq_h;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic inc_i = 1'b0;
  logic adj_i = 1'b0;

  logic [3:0] lsd24, lsd12;
  logic [1:0] msd24, msd12;
  logic       pm24, pm12, dia24, dia12;
  logic [7:0] obs24, obs12;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference: absolute hour 0..23 plus the last sampled button level
  int   m_h   = 0;
  logic m_adj = 1'b0;
  logic m_dia = 1'b0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_v;

  maq_h #(.MODO_24H(1'b1)) dut24 (
    .clk(clk), .rst(rst), .incrementa_hora(inc_i), .ajuste_hora(adj_i),
    .bcd_h_lsd(lsd24), .bcd_h_msd(msd24), .pm(pm24), .incrementa_dia(dia24)
  );

  maq_h #(.MODO_24H(1'b0)) dut12 (
    .clk(clk), .rst(rst), .incrementa_hora(inc_i), .ajuste_hora(adj_i),
    .bcd_h_lsd(lsd12), .bcd_h_msd(msd12), .pm(pm12), .incrementa_dia(dia12)
  );

  assign obs24 = {msd24, lsd24, pm24, dia24};
  assign obs12 = {msd12, lsd12, pm12, dia12};

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [7:0] enc24(input int h, input logic d);
    return {2'(h / 10), 4'(h % 10), (h >= 12), d};
  endfunction

  function automatic logic [7:0] enc12(input int h, input logic d);
    int hh;
    hh = h % 12;
    if (hh == 0) hh = 12;
    return {2'(hh / 10), 4'(hh % 10), (h >= 12), d};
  endfunction

  task automatic drive(input logic inc, input logic adj);
    logic ev;
    ev    = adj & ~m_adj;
    m_dia = inc && (m_h == 23);
    if (inc || ev) m_h = (m_h + 1) % 24;
    m_adj = adj;
    exp_q.push_back({enc24(m_h, m_dia), enc12(m_h, m_dia)});
    inc_i = inc;
    adj_i = adj;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic adj_level);
    rst   = 1'b0;
    inc_i = 1'b0;
    adj_i = adj_level;
    m_h   = 0;
    m_adj = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_chk++;
    if (obs24 !== 8'b00_0000_0_0) begin
      n_fail++;
      $display("FAIL reset24: got %b expected %b", obs24, 8'b00_0000_0_0);
    end
    n_chk++;
    if (obs12 !== 8'b01_0010_0_0) begin
      n_fail++;
      $display("FAIL reset12: got %b expected %b", obs12, 8'b01_0010_0_0);
    end
    do_reset(1'b0);
  endtask

  task automatic test_day_rollover;
    do_reset(1'b0);
    for (int i = 1; i <= 24; i++) begin
      drive(1'b1, 1'b0);
      exp_v = exp_q.pop_front();
      n_chk++;
      if ({obs24, obs12} !== exp_v) begin
        n_fail++;
        $display("FAIL rollover pulse %0d: got %h expected %h", i, {obs24, obs12}, exp_v);
      end
      if (i == 12) begin
        n_chk++;
        if ({pm24, obs12} !== {1'b1, 8'b01_0010_1_0}) begin
          n_fail++;
          $display("FAIL noon: got pm24=%b h12=%b expected 1 01_0010_1_0", pm24, obs12);
        end
      end
      if (i == 23) begin
        n_chk++;
        if ({obs24, obs12} !== {8'b10_0011_1_0, 8'b01_0001_1_0}) begin
          n_fail++;
          $display("FAIL eleven_pm: got %b_%b", obs24, obs12);
        end
      end
      if (i == 24) begin
        n_chk++;
        if ({obs24, obs12} !== {8'b00_0000_0_1, 8'b01_0010_0_1}) begin
          n_fail++;
          $display("FAIL day_wrap: got %b_%b expected 00000001_01001001", obs24, obs12);
        end
      end
      drive(1'b0, 1'b0);
      exp_v = exp_q.pop_front();
      n_chk++;
      if ({obs24, obs12} !== exp_v) begin
        n_fail++;
        $display("FAIL rollover idle %0d: got %h expected %h", i, {obs24, obs12}, exp_v);
      end
    end
  endtask

  task automatic test_carry_09;
    do_reset(1'b0);
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 1'b0);
      exp_v = exp_q.pop_front();
      n_chk++;
      if ({obs24, obs12} !== exp_v) begin
        n_fail++;
        $display("FAIL carry step %0d: got %h expected %h", i, {obs24, obs12}, exp_v);
      end
    end
    n_chk++;
    if ({obs24, obs12} !== {8'b01_0000_0_0, 8'b01_0000_0_0}) begin
      n_fail++;
      $display("FAIL carry_09_10: got %b_%b expected 01000000_01000000", obs24, obs12);
    end
  endtask

  task automatic test_adjust_hold;
    do_reset(1'b0);
    for (int i = 1; i <= 23; i++) begin
      drive(1'b1, 1'b0);
      void'(exp_q.pop_front());
    end
    for (int i = 1; i <= 10; i++) begin
      drive(1'b0, 1'b1);
      exp_v = exp_q.pop_front();
      n_chk++;
      if ({obs24, obs12} !== exp_v) begin
        n_fail++;
        $display("FAIL adjust hold cycle %0d: got %h expected %h", i, {obs24, obs12}, exp_v);
      end
    end
    n_chk++;
    if ({obs24, obs12} !== {8'b00_0000_0_0, 8'b01_0010_0_0}) begin
      n_fail++;
      $display("FAIL adjust_wrap: got %b_%b expected 00000000_01001000", obs24, obs12);
    end
  endtask

  task automatic test_reset_with_button;
    do_reset(1'b1);
    for (int i = 1; i <= 6; i++) begin
      drive(1'b0, 1'b1);
      exp_v = exp_q.pop_front();
      n_chk++;
      if ({obs24, obs12} !== exp_v) begin
        n_fail++;
        $display("FAIL button after reset cycle %0d: got %h expected %h", i, {obs24, obs12}, exp_v);
      end
    end
    n_chk++;
    if ({obs24, obs12} !== {8'b00_0001_0_0, 8'b00_0001_0_0}) begin
      n_fail++;
      $display("FAIL single_adjust: got %b_%b expected 00000100_00000100", obs24, obs12);
    end
  endtask

  task automatic test_back_to_back;
    do_reset(1'b0);
    for (int i = 1; i <= 23; i++) begin
      drive(1'b1, 1'b0);
      void'(exp_q.pop_front());
    end
    drive(1'b1, 1'b1);
    exp_v = exp_q.pop_front();
    n_chk++;
    if ({obs24, obs12} !== exp_v) begin
      n_fail++;
      $display("FAIL coincident step: got %h expected %h", {obs24, obs12}, exp_v);
    end
    n_chk++;
    if ({obs24, obs12} !== {8'b00_0000_0_1, 8'b01_0010_0_1}) begin
      n_fail++;
      $display("FAIL coincident_wrap: got %b_%b expected 00000001_01001001", obs24, obs12);
    end
    // Asynchronous reset mid-pulse, well away from any clock edge
    #2;
    rst = 1'b0;
    #1;
    n_chk++;
    if ({obs24, obs12} !== {8'b00_0000_0_0, 8'b01_0010_0_0}) begin
      n_fail++;
      $display("FAIL async_reset_pulse: got %b_%b expected 00000000_01001000", obs24, obs12);
    end
    do_reset(1'b0);
  endtask

  initial begin
    test_reset();
    test_day_rollover();
    test_carry_09();
    test_adjust_hold();
    test_reset_with_button();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
